// File: rtl/line_mem_responder_if.sv
// ---------------------------------------------------------------------------
// line_mem_if
// Cache-to-memory line interface. The cache (master) issues line-granular
// read/write requests and holds them until it sees a one-cycle ready pulse
// from the memory responder (slave).
//
// Signals:
//   mem_req_valid   master->slave  request valid, held until ready
//   mem_req_rw      master->slave  0 = read line, 1 = write line
//   mem_req_addr    master->slave  byte address (low 4 bits ignored)
//   mem_req_data    master->slave  write line, word k in bits [32k+31:32k]
//   mem_data_ready  slave->master  one-cycle completion pulse
//   mem_data_data   slave->master  read line, valid while ready is high
// ---------------------------------------------------------------------------
interface line_mem_if #(
    parameter int LINE_W = 128
) ();
    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [31:0]       mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_data_ready;
    logic [LINE_W-1:0] mem_data_data;

    modport master (
        output mem_req_valid,
        output mem_req_rw,
        output mem_req_addr,
        output mem_req_data,
        input  mem_data_ready,
        input  mem_data_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_rw,
        input  mem_req_addr,
        input  mem_req_data,
        output mem_data_ready,
        output mem_data_data
    );
endinterface

// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
// Responder end of the cache-to-memory line interface. Accepts one line
// read or write at a time and answers with a one-cycle ready pulse a fixed
// LATENCY cycles after the request is accepted. Backing store holds
// 2**LINE_ADDR_BITS lines of LINE_W bits; every word initially holds its
// own byte address.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (store contents untouched)
//   bus        line_mem_if slave modport (request in, ready/data out)
//   busy       high whenever the FSM is not in IDLE
//   rd_count   completed reads since reset (wraps at 2**32)
//   wr_count   completed writes since reset (wraps at 2**32)
// ---------------------------------------------------------------------------
module line_mem_responder #(
    parameter int LATENCY        = 4,
    parameter int LINE_ADDR_BITS = 14,
    parameter int LINE_W         = 128
) (
    input  logic        clk,
    input  logic        rst,
    line_mem_if.slave   bus,
    output logic        busy,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int DEPTH = 1 << LINE_ADDR_BITS;
    localparam int WORDS = LINE_W / 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    // Address-pattern line: word k of line idx = (idx << 4) | (k << 2).
    function automatic logic [LINE_W-1:0] line_pattern(input logic [LINE_ADDR_BITS-1:0] idx);
        logic [LINE_W-1:0] line;
        line = '0;
        for (int k = 0; k < WORDS; k++) begin
            line[32*k +: 32] = (32'(idx) << 4) | (32'(k) << 2);
        end
        return line;
    endfunction

    // The store holds each line XORed with its address pattern, so an
    // all-zero store reads back as the address-pattern preload.
    logic [LINE_W-1:0] store [DEPTH] = '{default: '0};

    logic [1:0]                state;
    logic [7:0]                cnt;
    logic                      rw_q;
    logic [LINE_ADDR_BITS-1:0] idx_q;
    logic [LINE_W-1:0]         wdata_q;
    logic [LINE_W-1:0]         rdata_q;

    logic [LINE_ADDR_BITS-1:0] req_idx;
    logic                      enter_resp;
    logic                      resp_rw;
    logic [LINE_ADDR_BITS-1:0] resp_idx;
    logic                      unused_addr;

    assign req_idx     = bus.mem_req_addr[4 +: LINE_ADDR_BITS];
    assign unused_addr = ^{bus.mem_req_addr[3:0], bus.mem_req_addr[31:4+LINE_ADDR_BITS]};

    // With LATENCY=1 RESP is entered straight from IDLE, before the request
    // has been latched, so the response side must look at the live request.
    always_comb begin
        enter_resp = 1'b0;
        resp_rw    = rw_q;
        resp_idx   = idx_q;
        if (state == IDLE) begin
            enter_resp = bus.mem_req_valid && (LATENCY == 1);
            resp_rw    = bus.mem_req_rw;
            resp_idx   = req_idx;
        end else if (state == WAIT) begin
            enter_resp = (cnt == 8'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rdata_q  <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_req_valid) begin
                        cnt   <= CNT_LOAD;
                        state <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 8'd1) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP:    state <= GAP;
                default: state <= IDLE;
            endcase

            // Counters step as RESP is entered so they are current while
            // ready is high; read data is fetched at the same edge.
            if (enter_resp) begin
                if (resp_rw) begin
                    wr_count <= wr_count + 32'd1;
                end else begin
                    rd_count <= rd_count + 32'd1;
                    rdata_q  <= store[resp_idx] ^ line_pattern(resp_idx);
                end
            end
        end
    end

    // Request capture; only the latched copy is used after accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.mem_req_valid) begin
            rw_q    <= bus.mem_req_rw;
            idx_q   <= req_idx;
            wdata_q <= bus.mem_req_data;
        end
    end

    // Write commits on the edge that leaves RESP; a reset in RESP drops it.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && rw_q) begin
            store[idx_q] <= wdata_q ^ line_pattern(idx_q);
        end
    end

    assign bus.mem_data_ready = (state == RESP);
    assign bus.mem_data_data  = rdata_q;
    assign busy               = (state != IDLE);

endmodule
